// File: rtl/bcd_text_writer.sv
// bcd_text_writer
// Takes one packed BCD word, converts each digit to an ASCII character code
// and writes the characters one per handshake into the character buffer,
// starting at the given address. Addresses wrap modulo 2^ADDR_W.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high; a source holds valid and its payload stable until that edge.
//
// Optional feature: define BCD_LZ_BLANK_EN to write leading zeros as
// BLANK_CHAR. The final digit is never blanked; invalid nibbles print '?'.
module bcd_text_writer #(
    parameter int          NDIG       = 5,
    parameter int          ADDR_W     = 12,
    parameter logic [7:0]  BLANK_CHAR = 8'h20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4*NDIG:0]   in_bcd,
    input  logic [ADDR_W-1:0] in_addr,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    localparam int KW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [4*NDIG-1:0]   bcd_q, bcd_d;
    logic [KW-1:0]       k_q, k_d;
    logic                wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [7:0]          wr_data_q, wr_data_d;
    logic                done_q, done_d;
`ifdef BCD_LZ_BLANK_EN
    logic                lz_q, lz_d;
`endif

    logic                transfer;
    logic                last_xfer;
    logic [KW-1:0]       k_next;
    logic [3:0]          digit;

    // The top bit of the input word is reserved and deliberately dropped.
    logic unused_reserved;
    assign unused_reserved = in_bcd[4*NDIG];

    // Select nibble k of a packed word (k = 0 is the most significant digit).
    function automatic logic [3:0] nibble(input logic [4*NDIG-1:0] w,
                                          input logic [KW-1:0]     k);
        logic [3:0] n;
        n = 4'h0;
        for (int i = 0; i < NDIG; i++) begin
            if (k == KW'(i)) n = w[4*i +: 4];
        end
        return n;
    endfunction

`ifdef BCD_LZ_BLANK_EN
    // Character for one digit; a leading zero is blanked unless it is the last digit.
    function automatic logic [7:0] to_char(input logic [3:0] d,
                                           input logic       last,
                                           input logic       lz);
        if (d > 4'd9)                       return 8'h3F;
        else if (lz && d == 4'd0 && !last)  return BLANK_CHAR;
        else                                return 8'h30 + {4'h0, d};
    endfunction
`else
    // Character for one digit; invalid nibbles print '?'.
    function automatic logic [7:0] to_char(input logic [3:0] d);
        if (d > 4'd9) return 8'h3F;
        else          return 8'h30 + {4'h0, d};
    endfunction
`endif

    assign transfer  = wr_valid_q && wr_ready;
    assign last_xfer = transfer && (k_q == K_LAST);

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            bcd_q      <= '0;
            k_q        <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            done_q     <= 1'b0;
`ifdef BCD_LZ_BLANK_EN
            lz_q       <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            bcd_q      <= bcd_d;
            k_q        <= k_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            done_q     <= done_d;
`ifdef BCD_LZ_BLANK_EN
            lz_q       <= lz_d;
`endif
        end
    end

    // Next-state logic: IDLE -> EMIT on accept, EMIT -> DONE after last write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid)  state_d = S_EMIT;
            S_EMIT:  if (last_xfer) state_d = S_DONE;
            S_DONE:                 state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // Output/datapath next values: present each character one cycle ahead.
    always_comb begin
        bcd_d      = bcd_q;
        k_d        = k_q;
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        done_d     = 1'b0;
        k_next     = k_q + KW'(1);
        digit      = 4'h0;
`ifdef BCD_LZ_BLANK_EN
        lz_d       = lz_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    // Latch the word and present digit 0 straight away.
                    bcd_d      = in_bcd[4*NDIG-1:0];
                    k_d        = '0;
                    digit      = nibble(in_bcd[4*NDIG-1:0], '0);
                    wr_valid_d = 1'b1;
                    wr_addr_d  = in_addr;
`ifdef BCD_LZ_BLANK_EN
                    wr_data_d  = to_char(digit, K_LAST == '0, 1'b1);
                    lz_d       = (digit == 4'd0);
`else
                    wr_data_d  = to_char(digit);
`endif
                end
            end
            S_EMIT: begin
                if (last_xfer) begin
                    wr_valid_d = 1'b0;
                    done_d     = 1'b1;
                end else if (transfer) begin
                    // lz_q carries "all digits so far were zero".
                    k_d        = k_next;
                    digit      = nibble(bcd_q, k_next);
                    wr_addr_d  = wr_addr_q + ADDR_W'(1);
`ifdef BCD_LZ_BLANK_EN
                    wr_data_d  = to_char(digit, k_next == K_LAST, lz_q);
                    lz_d       = lz_q && (digit == 4'd0);
`else
                    wr_data_d  = to_char(digit);
`endif
                end
            end
            default: ;
        endcase
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign wr_valid  = wr_valid_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign done      = done_q;
    assign state_dbg = state_q;

endmodule

// File: doc/bcd_text_writer.md
Name: bcd_text_writer

Overview:
- Sequential consumer of the packed BCD word from the binary-to-BCD converter.
- Turns each digit into an ASCII character code and writes the characters, one per handshake, into the VGA text/character buffer at a given start address.
- Used to print matrix result values on screen.
- Optional blanking of leading zeros.

Parameters:
- NDIG, 5, number of BCD digits in the input word.
- ADDR_W, 12, width of the character-buffer address.
- BLANK_CHAR, 8'h20, character code written for a blanked leading zero.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  block can accept a request (high only in IDLE).
- in_bcd  input  4*NDIG+1  packed BCD; nibble k = in_bcd[4k+3:4k], k=0 is the most significant digit; bit 4*NDIG reserved and ignored.
- in_addr  input  ADDR_W  buffer address for digit 0.
- wr_valid  output  1  character write valid.
- wr_ready  input  1  buffer accepts the write.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  8  character code.
- busy  output  1  state != IDLE.
- done  output  1  one-cycle pulse after the last write.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low.
- Reset values: state=IDLE, wr_valid=0, wr_addr=0, wr_data=0, done=0, digit index k=0, lz=0. The first cycle after reset has in_ready=1 and busy=0.
- States: IDLE -> EMIT -> DONE -> IDLE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch in_bcd and in_addr;
  - set k=0 and lz=1;
  - go to EMIT.
  - No input is accepted in any other state (in_ready=0); in_valid is ignored there.
- EMIT: registered wr_valid=1. wr_addr = latched_addr + k, modulo 2^ADDR_W (wraps). wr_data = char(k).
  - The first write is presented on the cycle after acceptance.
  - On wr_valid&&wr_ready: the write transfers. Then:
    - if k==NDIG-1, drop wr_valid and go to DONE;
    - otherwise k++ and present the next character on the next cycle. With wr_ready held high this gives one write per cycle, back-to-back.
  - While wr_ready=0: wr_valid, wr_addr and wr_data hold stable. No digit is skipped or duplicated.
- DONE: done=1 for exactly one cycle, then IDLE. in_ready returns high the cycle after done.
- Latency with wr_ready=1 and acceptance at cycle 0:
  - writes on cycles 1..NDIG;
  - done on cycle NDIG+1;
  - in_ready on cycle NDIG+2.
- char(k), for digit d = nibble k:
  - d<=9: 8'h30+d. Blanking may override this for leading zeros (see Optional Feature).
  - d>9 (invalid BCD): 8'h3F ('?'), never blanked.
  - lz clears on the first digit that is nonzero or invalid, and stays cleared for the rest of the word.
  - The last digit (k==NDIG-1) is never blanked, so a value of zero prints '0'.
- Reset mid-operation: rst_n=0 at any edge forces IDLE with the reset values above.
  - wr_valid is low in the following cycle.
  - No further writes and no done pulse for the aborted word.
- A simultaneous in_valid and reset release: the request is not accepted on the reset edge. It is accepted on the first edge with rst_n=1.

Optional Feature:
- Macro BCD_LZ_BLANK_EN.
- Defined: while lz=1, a zero digit with k<NDIG-1 is written as BLANK_CHAR. The write still happens, so stale characters are overwritten.
- Not defined: lz logic is absent; every valid digit prints as 8'h30+d, including leading zeros. Invalid-nibble handling is unchanged.

Test Plan:
- Value 1234, BCD_LZ_BLANK_EN defined, NDIG=5, ADDR_W=12, wr_ready=1, in_bcd=21'h43210, in_addr=12'h100 -> (100,20), (101,31), (102,32), (103,33), (104,34) on cycles 1-5; done on cycle 6; in_ready on cycle 7.
- Value zero, in_bcd=0 -> with the macro: four writes of 8'h20, then 8'h30. Without the macro: five writes of 8'h30.
- Backpressure: wr_ready=0 for 3 cycles while digit 2 is presented -> wr_valid/wr_addr/wr_data stable through the stall, exactly 5 transfers, correct order, done after the 5th.
- Address wrap: in_addr=12'hFFE -> write addresses FFE, FFF, 000, 001, 002.
- Invalid digit: in_bcd=21'h000A0 with the macro -> 20, 3F, 30, 30, 30. Also pulse in_valid while busy -> ignored, no second run.
- Reset mid-operation: rst_n low for 1 cycle after the 2nd transfer -> wr_valid=0 next cycle, no done, in_ready=1. A new request then produces a correct full 5-write sequence.
